// File: rtl/rx_elastic_wr_ctrl.sv
// rx_elastic_wr_ctrl
// Write-side controller for the PCS RX elastic FIFO (recovered-clock domain).
// Buffers one decoded character so that a complete /I2/ idle pair
// (K28.5 followed by D16.2) can be dropped before either half reaches the
// FIFO once the fill level is at or above the high watermark. It tracks the
// fill level from the synchronised Gray read pointer and flags overflow.

module rx_elastic_wr_ctrl #(
    parameter int ADDRSIZE = 3,
    parameter int HI_WM    = 6
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic                in_valid,
    input  logic [7:0]          in_data,
    input  logic                in_k,
    input  logic                wfull,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    input  logic                ovf_clr,
    output logic                winc,
    output logic [8:0]          wdata,
    output logic [ADDRSIZE:0]   fill,
    output logic                ovf,
    output logic [15:0]         del_cnt
);

    localparam logic [7:0]        K28_5   = 8'hBC;
    localparam logic [7:0]        D16_2   = 8'h50;
    localparam int unsigned       PW      = ADDRSIZE + 1;
    localparam logic [ADDRSIZE:0] HI_WM_W = HI_WM[ADDRSIZE:0];

    // Hold stage
    logic               r_s1_valid;
    logic               r_s1_k;
    logic [7:0]         r_s1_data;

    // Write port and bookkeeping
    logic               r_winc;
    logic [8:0]         r_wdata;
    logic [ADDRSIZE:0]  r_wcnt;
    logic               r_ovf;
    logic [15:0]        r_del_cnt;

    // Combinational terms
    logic [ADDRSIZE:0]  w_rbin;
    logic [ADDRSIZE:0]  w_fill;
    logic               w_s1_is_k285;
    logic               w_in_is_d162;
    logic               w_del;
    logic               w_commit;
    logic               w_lost;

    // Gray-to-binary conversion of the synchronised read pointer:
    // each binary bit is the XOR of the Gray bits from the MSB down to it.
    always_comb begin
        w_rbin = '0;
        for (int unsigned i = 0; i < PW; i++) begin
            w_rbin[i] = ^(wq2_rptr >> i);
        end
    end

    // Fill level and /I2/ pair detection
    always_comb begin
        w_fill       = r_wcnt - w_rbin;
        w_s1_is_k285 = r_s1_k && (r_s1_data == K28_5);
        w_in_is_d162 = !in_k && (in_data == D16_2);
        w_del        = in_valid && r_s1_valid && w_s1_is_k285 &&
                       w_in_is_d162 && (w_fill >= HI_WM_W);
        w_commit     = r_winc && !wfull;
        w_lost       = r_winc && wfull;
    end

    // Hold stage and registered FIFO write port: drop the pair, shift a new
    // character in, or hold the buffered character across an input gap.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            r_s1_valid <= 1'b0;
            r_s1_k     <= 1'b0;
            r_s1_data  <= '0;
            r_winc     <= 1'b0;
            r_wdata    <= '0;
        end else if (w_del) begin
            r_s1_valid <= 1'b0;
            r_winc     <= 1'b0;
        end else if (in_valid) begin
            r_winc     <= r_s1_valid;
            r_wdata    <= {r_s1_k, r_s1_data};
            r_s1_k     <= in_k;
            r_s1_data  <= in_data;
            r_s1_valid <= 1'b1;
        end else begin
            r_winc     <= 1'b0;
        end
    end

    // Binary write count mirroring the FIFO write pointer; a write against
    // a full FIFO is discarded by the FIFO and so is not counted.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            r_wcnt <= '0;
        end else if (w_commit) begin
            r_wcnt <= r_wcnt + 1'b1;
        end
    end

    // Sticky overflow flag; a lost write on the same edge as a clear wins.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            r_ovf <= 1'b0;
        end else if (w_lost) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    // Saturating count of deleted /I2/ pairs
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            r_del_cnt <= '0;
        end else if (w_del && (r_del_cnt != '1)) begin
            r_del_cnt <= r_del_cnt + 16'd1;
        end
    end

    assign winc    = r_winc;
    assign wdata   = r_wdata;
    assign fill    = w_fill;
    assign ovf     = r_ovf;
    assign del_cnt = r_del_cnt;

endmodule

// File: tb/tb_rx_elastic_wr_ctrl.sv
// tb_rx_elastic_wr_ctrl
// Directed bench for rx_elastic_wr_ctrl (ADDRSIZE=3, HI_WM=6). Inputs are
// driven 1 time unit after each rising edge and outputs are sampled there.

module tb_rx_elastic_wr_ctrl;

    logic        wclk;
    logic        wrst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_k;
    logic        wfull;
    logic [3:0]  wq2_rptr;
    logic        ovf_clr;
    logic        winc;
    logic [8:0]  wdata;
    logic [3:0]  fill;
    logic        ovf;
    logic [15:0] del_cnt;

    int total = 0;
    int bad   = 0;

    rx_elastic_wr_ctrl #(
        .ADDRSIZE (3),
        .HI_WM    (6)
    ) dut (
        .wclk     (wclk),
        .wrst     (wrst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_k     (in_k),
        .wfull    (wfull),
        .wq2_rptr (wq2_rptr),
        .ovf_clr  (ovf_clr),
        .winc     (winc),
        .wdata    (wdata),
        .fill     (fill),
        .ovf      (ovf),
        .del_cnt  (del_cnt)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    function automatic logic [3:0] bin2gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic send(input logic k, input logic [7:0] d);
        in_valid = 1'b1;
        in_k     = k;
        in_data  = d;
        @(posedge wclk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(posedge wclk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_k     = 1'b0;
        in_data  = 8'h00;
        wfull    = 1'b0;
        ovf_clr  = 1'b0;
        wq2_rptr = 4'b0000;
        wrst     = 1'b1;
        #2;
        wrst     = 1'b0;
    endtask

    task automatic test_reset();
        wrst     = 1'b1;
        in_valid = 1'b1;
        in_k     = 1'b0;
        in_data  = 8'h55;
        wfull    = 1'b0;
        ovf_clr  = 1'b0;
        wq2_rptr = 4'b0000;
        @(posedge wclk);
        @(posedge wclk);
        #1;
        total++; if (winc !== 1'b0) begin bad++; $display("FAIL reset_winc got=%0b exp=0", winc); end
        total++; if (wdata !== 9'h000) begin bad++; $display("FAIL reset_wdata got=%03h exp=000", wdata); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0b exp=0", ovf); end
        total++; if (del_cnt !== 16'd0) begin bad++; $display("FAIL reset_del_cnt got=%0d exp=0", del_cnt); end
        total++; if (fill !== 4'd0) begin bad++; $display("FAIL reset_fill got=%0d exp=0", fill); end
        // read pointer at binary 3 while held in reset: fill = 0 - 3 mod 16
        wq2_rptr = bin2gray(4'd3);
        #1;
        total++; if (fill !== 4'd13) begin bad++; $display("FAIL reset_fill_rptr3 got=%0d exp=13", fill); end
        in_valid = 1'b0;
        wq2_rptr = 4'b0000;
        wrst     = 1'b0;
    endtask

    task automatic test_passthrough();
        do_reset();
        send(1'b0, 8'h11);
        total++; if (winc !== 1'b0) begin bad++; $display("FAIL pass_first_winc got=%0b exp=0", winc); end
        send(1'b0, 8'h22);
        total++; if (winc !== 1'b1 || wdata !== 9'h011) begin bad++; $display("FAIL pass_w11 got=%0b/%03h exp=1/011", winc, wdata); end
        send(1'b0, 8'h33);
        total++; if (winc !== 1'b1 || wdata !== 9'h022) begin bad++; $display("FAIL pass_w22 got=%0b/%03h exp=1/022", winc, wdata); end
        idle();
        total++; if (winc !== 1'b0) begin bad++; $display("FAIL pass_idle_winc got=%0b exp=0", winc); end
        total++; if (fill !== 4'd2) begin bad++; $display("FAIL pass_fill got=%0d exp=2", fill); end
    endtask

    task automatic test_delete();
        do_reset();
        for (int j = 1; j <= 7; j++) send(1'b0, 8'(j));
        send(1'b1, 8'hBC);
        total++; if (winc !== 1'b1 || wdata !== 9'h007) begin bad++; $display("FAIL del_w07 got=%0b/%03h exp=1/007", winc, wdata); end
        total++; if (fill !== 4'd6) begin bad++; $display("FAIL del_fill_pre got=%0d exp=6", fill); end
        send(1'b0, 8'h50);
        total++; if (winc !== 1'b0) begin bad++; $display("FAIL del_winc got=%0b exp=0", winc); end
        total++; if (del_cnt !== 16'd1) begin bad++; $display("FAIL del_cnt got=%0d exp=1", del_cnt); end
        idle();
        idle();
        // the 7 data chars are committed; the dropped pair adds nothing
        total++; if (winc !== 1'b0 || fill !== 4'd7) begin bad++; $display("FAIL del_fill_post got=%0b/%0d exp=0/7", winc, fill); end
        send(1'b0, 8'h44);
        total++; if (winc !== 1'b0) begin bad++; $display("FAIL del_after_winc got=%0b exp=0", winc); end
        send(1'b0, 8'h45);
        total++; if (winc !== 1'b1 || wdata !== 9'h044) begin bad++; $display("FAIL del_after_w44 got=%0b/%03h exp=1/044", winc, wdata); end
        total++; if (fill !== 4'd7) begin bad++; $display("FAIL del_after_fill got=%0d exp=7", fill); end
    endtask

    task automatic test_gap();
        do_reset();
        for (int j = 1; j <= 7; j++) send(1'b0, 8'(j));
        send(1'b1, 8'hBC);
        idle();
        idle();
        send(1'b0, 8'h50);
        total++; if (winc !== 1'b0) begin bad++; $display("FAIL gap_winc got=%0b exp=0", winc); end
        total++; if (del_cnt !== 16'd1) begin bad++; $display("FAIL gap_del_cnt got=%0d exp=1", del_cnt); end
        total++; if (fill !== 4'd7) begin bad++; $display("FAIL gap_fill got=%0d exp=7", fill); end
    endtask

    task automatic test_nonpair();
        // K28.5 followed by D21.5 at fill 6: both written
        do_reset();
        for (int j = 1; j <= 7; j++) send(1'b0, 8'(j));
        send(1'b1, 8'hBC);
        send(1'b0, 8'hB5);
        total++; if (winc !== 1'b1 || wdata !== 9'h1BC) begin bad++; $display("FAIL np_wK got=%0b/%03h exp=1/1bc", winc, wdata); end
        send(1'b0, 8'h60);
        total++; if (winc !== 1'b1 || wdata !== 9'h0B5) begin bad++; $display("FAIL np_wB5 got=%0b/%03h exp=1/0b5", winc, wdata); end
        total++; if (del_cnt !== 16'd0) begin bad++; $display("FAIL np_del_cnt got=%0d exp=0", del_cnt); end
        // /I2/ at fill 5, just below the watermark: both written
        do_reset();
        for (int j = 1; j <= 6; j++) send(1'b0, 8'(j));
        send(1'b1, 8'hBC);
        total++; if (fill !== 4'd5) begin bad++; $display("FAIL wm_fill got=%0d exp=5", fill); end
        send(1'b0, 8'h50);
        total++; if (winc !== 1'b1 || wdata !== 9'h1BC) begin bad++; $display("FAIL wm_wK got=%0b/%03h exp=1/1bc", winc, wdata); end
        send(1'b0, 8'h61);
        total++; if (winc !== 1'b1 || wdata !== 9'h050) begin bad++; $display("FAIL wm_wD got=%0b/%03h exp=1/050", winc, wdata); end
        total++; if (del_cnt !== 16'd0) begin bad++; $display("FAIL wm_del_cnt got=%0d exp=0", del_cnt); end
    endtask

    task automatic test_overflow();
        do_reset();
        send(1'b0, 8'h11);
        send(1'b0, 8'h22);
        wfull = 1'b1;
        send(1'b0, 8'h33);
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_set got=%0b exp=1", ovf); end
        total++; if (fill !== 4'd0) begin bad++; $display("FAIL ovf_wcnt_hold got=%0d exp=0", fill); end
        wfull = 1'b0;
        idle();
        total++; if (fill !== 4'd1 || ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%0d/%0b exp=1/1", fill, ovf); end
        ovf_clr = 1'b1;
        idle();
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%0b exp=0", ovf); end
        ovf_clr = 1'b0;
        send(1'b0, 8'h44);
        total++; if (winc !== 1'b1 || wdata !== 9'h033) begin bad++; $display("FAIL ovf_w33 got=%0b/%03h exp=1/033", winc, wdata); end
        wfull   = 1'b1;
        ovf_clr = 1'b1;
        send(1'b0, 8'h55);
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_set_wins got=%0b exp=1", ovf); end
        total++; if (fill !== 4'd1) begin bad++; $display("FAIL ovf_fill2 got=%0d exp=1", fill); end
        wfull   = 1'b0;
        ovf_clr = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        send(1'b0, 8'hAA);
        send(1'b0, 8'hBB);
        send(1'b0, 8'hCC);
        idle();
        total++; if (fill !== 4'd2) begin bad++; $display("FAIL mid_fill_pre got=%0d exp=2", fill); end
        #2;
        wrst = 1'b1;
        #1;
        total++; if (winc !== 1'b0 || fill !== 4'd0 || wdata !== 9'h000) begin bad++; $display("FAIL mid_reset got=%0b/%0d/%03h exp=0/0/000", winc, fill, wdata); end
        wrst = 1'b0;
        send(1'b0, 8'h77);
        total++; if (winc !== 1'b0) begin bad++; $display("FAIL mid_s1_discard got=%0b exp=0", winc); end
        send(1'b0, 8'h78);
        total++; if (winc !== 1'b1 || wdata !== 9'h077) begin bad++; $display("FAIL mid_w77 got=%0b/%03h exp=1/077", winc, wdata); end
    endtask

    task automatic test_wrap();
        logic [3:0] rb;
        logic [3:0] ew;
        logic [3:0] ef;
        do_reset();
        rb = 4'd0;
        ew = 4'd0;
        for (int i = 0; i < 40; i++) begin
            wq2_rptr = bin2gray(rb);
            send(1'b0, 8'(i + 1));
            // first two sends commit nothing; after that one write per edge
            if (i >= 2) ew = ew + 4'd1;
            ef = ew - rb;
            total++; if (fill !== ef || fill > 4'd8) begin bad++; $display("FAIL wrap_fill[%0d] got=%0d exp=%0d", i, fill, ef); end
            if (ef >= 4'd4) rb = rb + 4'd1;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_delete();
        test_gap();
        test_nonpair();
        test_overflow();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
